top_main_ctrl: RTL and testbench

- Multi-cycle sequencer for the top_main datapath (register file, ALU, data memory).
- Accepts instruction words over a valid/ready handshake and decodes them.
- Steps through fetch/decode/execute/memory/writeback, driving opcode, register and memory addresses and write strobes one phase at a time.
- Captures the ALU zero flag and keeps retire and illegal-instruction status.

---
 rtl/top_main_ctrl_pkg.sv | 45 ++++
 rtl/top_main_ctrl_decode.sv | 40 ++++
 rtl/top_main_ctrl.sv | 166 ++++++++++++++++
 tb/tb_top_main_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/top_main_ctrl_pkg.sv
// Shared types, field layout and opcode classes for the top_main sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package top_main_ctrl_pkg;

  // Default datapath widths; the top-level parameters default to these.
  localparam int OPCODE_W_DEF   = 4;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int MEM_ADDR_W_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  // Instruction word layout, LSB first: {op, rd, rs1, addr}.
  localparam int ADDR_LSB = 0;
  localparam int RS1_LSB  = ADDR_LSB + MEM_ADDR_W_DEF;
  localparam int RD_LSB   = RS1_LSB + REG_ADDR_W_DEF;
  localparam int OP_LSB   = RD_LSB + REG_ADDR_W_DEF;
  localparam int INSTR_W  = OP_LSB + OPCODE_W_DEF;

  // Named opcodes outside the ALU range.
  localparam logic [OPCODE_W_DEF-1:0] OP_LOAD  = 4'h8;
  localparam logic [OPCODE_W_DEF-1:0] OP_STORE = 4'h9;
  localparam logic [OPCODE_W_DEF-1:0] OP_HALT  = 4'hE;
  localparam logic [OPCODE_W_DEF-1:0] OP_NOP   = 4'hF;

  // Sequencer phases.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Opcodes 0x0..0x7 go to the ALU.
  function automatic logic is_alu(input logic [OPCODE_W_DEF-1:0] op);
    return (op < OP_LOAD);
  endfunction

  // The gap between STORE and HALT (0xA..0xD) is undefined.
  function automatic logic is_illegal(input logic [OPCODE_W_DEF-1:0] op);
    return (op > OP_STORE) && (op < OP_HALT);
  endfunction

endpackage

// File: rtl/top_main_ctrl_decode.sv
// Splits an instruction word into fields and classifies its opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds the word stable in its register.
module top_main_ctrl_decode
  import top_main_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0]        instr_i,
  output logic [OPCODE_W_DEF-1:0]   op_o,
  output logic [REG_ADDR_W_DEF-1:0] rd_o,
  output logic [REG_ADDR_W_DEF-1:0] rs1_o,
  output logic [REG_ADDR_W_DEF-1:0] rs2_o,
  output logic [MEM_ADDR_W_DEF-1:0] addr_o,
  output logic                      is_alu_o,
  output logic                      is_load_o,
  output logic                      is_store_o,
  output logic                      is_halt_o,
  output logic                      is_nop_o,
  output logic                      is_illegal_o
);

  // Field split: rs2 shares the low bits of the memory address field.
  always_comb begin
    op_o   = instr_i[OP_LSB   +: OPCODE_W_DEF];
    rd_o   = instr_i[RD_LSB   +: REG_ADDR_W_DEF];
    rs1_o  = instr_i[RS1_LSB  +: REG_ADDR_W_DEF];
    addr_o = instr_i[ADDR_LSB +: MEM_ADDR_W_DEF];
    rs2_o  = addr_o[REG_ADDR_W_DEF-1:0];
  end

  // Opcode class: exactly one of these is set for any opcode value.
  always_comb begin
    is_alu_o     = is_alu(op_o);
    is_load_o    = (op_o == OP_LOAD);
    is_store_o   = (op_o == OP_STORE);
    is_halt_o    = (op_o == OP_HALT);
    is_nop_o     = (op_o == OP_NOP);
    is_illegal_o = is_illegal(op_o);
  end

endmodule

// File: rtl/top_main_ctrl.sv
// Multi-cycle sequencer: accept, decode, then drive ALU/memory/regfile phase by phase.
// Latency: accept edge to ready again is ALU 3, LOAD 3, STORE 2, NOP/illegal 1 cycles.
// Backpressure: instr_ready is high only in IDLE; HALT holds it low until reset.
module top_main_ctrl
  import top_main_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = OPCODE_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    instr_valid,
  output logic                                    instr_ready,
  input  logic [OPCODE_W+2*REG_ADDR_W+MEM_ADDR_W-1:0] instr,
  output logic [OPCODE_W-1:0]                     dp_opcode,
  output logic [REG_ADDR_W-1:0]                   dp_reg1_addr,
  output logic [REG_ADDR_W-1:0]                   dp_reg2_addr,
  output logic [REG_ADDR_W-1:0]                   dp_rd_addr,
  output logic [MEM_ADDR_W-1:0]                   dp_mem_addr,
  output logic                                    dp_reg_we,
  output logic                                    dp_mem_we,
  output logic                                    dp_mem_re,
  input  logic                                    dp_zero,
  output logic                                    zero_flag,
  output logic                                    busy,
  output logic                                    halted,
  output logic                                    illegal,
  output logic [CNT_W-1:0]                        retired_count
);

  localparam int IW = OPCODE_W + 2*REG_ADDR_W + MEM_ADDR_W;

  state_e          state_q;
  logic [IW-1:0]   ir_q;
  logic            reg_we_q;
  logic            mem_we_q;
  logic            mem_re_q;
  logic            zero_q;
  logic            halted_q;
  logic            illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [OPCODE_W-1:0]   dec_op;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [MEM_ADDR_W-1:0] dec_addr;
  logic dec_alu, dec_load, dec_store, dec_halt, dec_nop, dec_illegal;

  // Decode always looks at the latched word, so the datapath fields cannot
  // follow the instr port while the sequencer is busy.
  top_main_ctrl_decode u_decode (
    .instr_i      (ir_q),
    .op_o         (dec_op),
    .rd_o         (dec_rd),
    .rs1_o        (dec_rs1),
    .rs2_o        (dec_rs2),
    .addr_o       (dec_addr),
    .is_alu_o     (dec_alu),
    .is_load_o    (dec_load),
    .is_store_o   (dec_store),
    .is_halt_o    (dec_halt),
    .is_nop_o     (dec_nop),
    .is_illegal_o (dec_illegal)
  );

  // Retire counter next value; wraps naturally at the top of its range.
  assign cnt_d = cnt_q + CNT_W'(1);

  // Sequencer: state, instruction register, strobes and status in one place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      reg_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      zero_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // Strobes are single-cycle: cleared unless the next state asserts one.
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_alu) begin
            state_q <= ST_EXEC;
          end else if (dec_load) begin
            state_q  <= ST_MEM;
            mem_re_q <= 1'b1;
          end else if (dec_store) begin
            state_q  <= ST_MEM;
            mem_we_q <= 1'b1;
          end else if (dec_halt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
            cnt_q    <= cnt_d;
          end else if (dec_nop) begin
            state_q <= ST_IDLE;
            cnt_q   <= cnt_d;
          end else if (dec_illegal) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // ALU result is sampled on the edge that leaves EXEC.
          zero_q   <= dp_zero;
          state_q  <= ST_WB;
          reg_we_q <= 1'b1;
        end
        ST_MEM: begin
          if (dec_load) begin
            state_q  <= ST_WB;
            reg_we_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= cnt_d;
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
          cnt_q   <= cnt_d;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status views derive from state only.
  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

  assign dp_opcode     = dec_op;
  assign dp_reg1_addr  = dec_rs1;
  assign dp_reg2_addr  = dec_rs2;
  assign dp_rd_addr    = dec_rd;
  assign dp_mem_addr   = dec_addr;
  assign dp_reg_we     = reg_we_q;
  assign dp_mem_we     = mem_we_q;
  assign dp_mem_re     = mem_re_q;
  assign zero_flag     = zero_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_top_main_ctrl.sv
// Directed bench for the top_main sequencer, checked with immediate assertions.
// Latency: each step advances one clock and samples 1 ns after the rising edge.
// Backpressure: instr_valid is held high through busy and HALT phases to probe ready.
module tb_top_main_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [13:0] instr = '0;
  logic [3:0]  dp_opcode;
  logic [2:0]  dp_reg1_addr, dp_reg2_addr, dp_rd_addr;
  logic [3:0]  dp_mem_addr;
  logic        dp_reg_we, dp_mem_we, dp_mem_re;
  logic        dp_zero = 1'b0;
  logic        zero_flag, busy, halted, illegal;
  logic [3:0]  retired_count;

  int n_total = 0;
  int n_pass  = 0;

  top_main_ctrl #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .dp_opcode     (dp_opcode),
    .dp_reg1_addr  (dp_reg1_addr),
    .dp_reg2_addr  (dp_reg2_addr),
    .dp_rd_addr    (dp_rd_addr),
    .dp_mem_addr   (dp_mem_addr),
    .dp_reg_we     (dp_reg_we),
    .dp_mem_we     (dp_mem_we),
    .dp_mem_re     (dp_mem_re),
    .dp_zero       (dp_zero),
    .zero_flag     (zero_flag),
    .busy          (busy),
    .halted        (halted),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [3:0] addr);
    return {op, rd, rs1, addr};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one edge; returns sampling the DECODE cycle.
  task automatic issue(input logic [13:0] w);
    instr_valid = 1'b1;
    instr       = w;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic strobes_none(input string tag);
    chk(tag, {13'd0, dp_reg_we, dp_mem_we, dp_mem_re}, 16'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {dp_reg_we, dp_mem_we, dp_mem_re}, 0);
    chk("rst_status", {zero_flag, halted, illegal}, 0);
    chk("rst_count", retired_count, 0);
    chk("rst_fields", {dp_opcode, dp_rd_addr, dp_reg1_addr, dp_mem_addr}, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", instr_ready, 1);

    // ALU 0x513: op1 rd2 rs1=1 rs2=3
    issue(14'h513);
    chk("alu_dec_busy", busy, 1);
    chk("alu_dec_ready", instr_ready, 0);
    chk("alu_opcode", dp_opcode, 4'h1);
    chk("alu_rs1", dp_reg1_addr, 3'd1);
    chk("alu_rs2", dp_reg2_addr, 3'd3);
    chk("alu_rd", dp_rd_addr, 3'd2);
    strobes_none("alu_dec_strobes");
    instr = mk(4'h7, 3'd6, 3'd6, 4'hF);   // ignored while busy
    tick();
    strobes_none("alu_exec_strobes");
    chk("alu_exec_rd_stable", dp_rd_addr, 3'd2);
    tick();
    chk("alu_wb_we", {dp_reg_we, dp_mem_we, dp_mem_re}, 3'b100);
    chk("alu_wb_rd", dp_rd_addr, 3'd2);
    chk("alu_wb_ready", instr_ready, 0);
    tick();
    chk("alu_done_ready", instr_ready, 1);
    strobes_none("alu_done_strobes");
    chk("alu_count", retired_count, 1);

    // LOAD then STORE with instr_valid held high
    instr_valid = 1'b1;
    instr = mk(4'h8, 3'd5, 3'd0, 4'hA);
    tick();
    instr = mk(4'h9, 3'd0, 3'd4, 4'h3);
    chk("ld_dec_rd", dp_rd_addr, 3'd5);
    strobes_none("ld_dec_strobes");
    tick();
    chk("ld_mem_strobes", {dp_reg_we, dp_mem_we, dp_mem_re}, 3'b001);
    chk("ld_mem_addr", dp_mem_addr, 4'hA);
    tick();
    chk("ld_wb_strobes", {dp_reg_we, dp_mem_we, dp_mem_re}, 3'b100);
    chk("ld_wb_rd", dp_rd_addr, 3'd5);
    tick();
    chk("ld_done_ready", instr_ready, 1);
    chk("ld_count", retired_count, 2);
    tick();
    instr_valid = 1'b0;
    chk("st_dec_op", dp_opcode, 4'h9);
    chk("st_dec_rs1", dp_reg1_addr, 3'd4);
    strobes_none("st_dec_strobes");
    tick();
    chk("st_mem_strobes", {dp_reg_we, dp_mem_we, dp_mem_re}, 3'b010);
    chk("st_mem_addr", dp_mem_addr, 4'h3);
    tick();
    chk("st_done_ready", instr_ready, 1);
    strobes_none("st_done_strobes");
    chk("st_count", retired_count, 3);

    // Zero-flag capture
    dp_zero = 1'b1;
    issue(mk(4'h2, 3'd1, 3'd2, 4'h3));
    tick();
    tick();
    chk("zf_set", zero_flag, 1);
    tick();
    dp_zero = 1'b0;
    issue(mk(4'h9, 3'd0, 3'd1, 4'h1));
    tick();
    tick();
    chk("zf_hold_store", zero_flag, 1);
    chk("zf_store_count", retired_count, 5);
    issue(mk(4'h3, 3'd1, 3'd2, 4'h3));
    tick();
    tick();
    chk("zf_clear", zero_flag, 0);
    tick();
    chk("zf_count", retired_count, 6);

    // Illegal and NOP
    issue(mk(4'hB, 3'd1, 3'd1, 4'h1));
    strobes_none("ill_dec_strobes");
    tick();
    chk("ill_flag", illegal, 1);
    chk("ill_ready", instr_ready, 1);
    strobes_none("ill_strobes");
    chk("ill_count", retired_count, 6);
    issue(mk(4'hF, 3'd0, 3'd0, 4'h0));
    tick();
    chk("nop_ready", instr_ready, 1);
    chk("nop_count", retired_count, 7);
    chk("ill_sticky", illegal, 1);

    // HALT holds off new work until reset
    issue(mk(4'hE, 3'd0, 3'd0, 4'h0));
    tick();
    chk("halt_flag", halted, 1);
    chk("halt_count", retired_count, 8);
    instr_valid = 1'b1;
    instr = 14'h513;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_ready_low", {instr_ready, halted, busy}, 3'b011);
    end
    strobes_none("halt_strobes");
    chk("halt_count_hold", retired_count, 8);
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_ready", instr_ready, 1);
    chk("halt_rst_illegal", illegal, 0);
    chk("halt_rst_count", retired_count, 0);
    #1 rst = 1'b0;
    tick();

    // Async reset during WB of an ALU op
    issue(14'h513);
    tick();
    tick();
    chk("mid_wb_we", dp_reg_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", dp_reg_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd", dp_rd_addr, 0);
    #1 rst = 1'b0;
    tick();
    chk("mid_rst_count", retired_count, 0);
    chk("mid_rst_ready", instr_ready, 1);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 15; i++) begin
      issue(mk(4'hF, 3'd0, 3'd0, 4'h0));
      tick();
    end
    chk("wrap_15", retired_count, 15);
    issue(mk(4'hF, 3'd0, 3'd0, 4'h0));
    tick();
    chk("wrap_0", retired_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
